// File: rtl/tp84_vol_lpf.sv
// Volume-dependent output low-pass: two cascaded first-order IIR stages on a
// 48 kHz sample tick, sharing one multiplier across a four-state sequencer.
module tp84_vol_lpf #(
    parameter int DIV   = 1024,
    parameter int COEF1 = 40004,
    parameter int COEF2 = 30573,
    parameter int COEF3 = 21287
) (
    input  logic               clk_49m,
    input  logic               reset,
    input  logic signed [15:0] sound_in,
    input  logic        [1:0]  vol_sel,
    output logic               sample_tick,
    output logic signed [15:0] sound_out,
    output logic               out_valid,
    output logic        [1:0]  o_dbg_state
);
    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ST1  = 2'd1;
    localparam logic [1:0] ST2  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic        [CW-1:0] r_div;
    logic        [1:0]    r_state;
    logic signed [15:0]   r_x;
    logic        [16:0]   r_k;
    logic signed [23:0]   r_y1;
    logic signed [23:0]   r_y2;
    logic signed [15:0]   r_sound_out;

    logic        [16:0]   w_k_sel;
    logic signed [24:0]   w_x_ext;
    logic signed [24:0]   w_y1_ext;
    logic signed [24:0]   w_y2_ext;
    logic signed [24:0]   w_d;
    logic signed [23:0]   w_base;
    logic signed [42:0]   w_prod;
    logic signed [24:0]   w_inc;
    logic signed [24:0]   w_sum;
    logic signed [23:0]   w_y_next;
    logic signed [23:0]   w_y2_int;
    logic signed [15:0]   w_sat;

    // Bypass is a unit-gain stage (k = 1.0 in Q16), so y tracks x exactly.
    always_comb begin
        w_k_sel = 17'd65536;
        case (vol_sel)
            2'd1:    w_k_sel = 17'(COEF1);
            2'd2:    w_k_sel = 17'(COEF2);
            2'd3:    w_k_sel = 17'(COEF3);
            default: w_k_sel = 17'd65536;
        endcase
    end

    assign w_x_ext  = {r_x[15], r_x, 8'h00};
    assign w_y1_ext = {r_y1[23], r_y1};
    assign w_y2_ext = {r_y2[23], r_y2};

    // The single multiplier: ST1 filters x into y1, ST2 filters the fresh y1 into y2.
    always_comb begin
        w_d    = w_x_ext - w_y1_ext;
        w_base = r_y1;
        if (r_state == ST2) begin
            w_d    = w_y1_ext - w_y2_ext;
            w_base = r_y2;
        end
    end

    assign w_prod   = 43'(w_d) * 43'($signed({1'b0, r_k}));
    assign w_inc    = 25'(w_prod >>> 16);
    assign w_sum    = {w_base[23], w_base} + w_inc;
    assign w_y_next = 24'(w_sum);
    assign w_y2_int = r_y2 >>> 8;

    always_comb begin
        w_sat = 16'(w_y2_int);
        if (w_y2_int > 24'sd32767)
            w_sat = 16'sh7fff;
        else if (w_y2_int < -24'sd32768)
            w_sat = 16'sh8000;
    end

    // out_valid is a one-cycle strobe with no back-pressure; sound_out carries
    // the new sample in that same cycle and holds it until the next strobe.
    assign sample_tick = (r_div == DIV_LAST);
    assign out_valid   = (r_state == DONE);
    assign sound_out   = (r_state == DONE) ? w_sat : r_sound_out;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk_49m) begin
        if (reset) begin
            r_div       <= '0;
            r_state     <= IDLE;
            r_x         <= '0;
            r_k         <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_sound_out <= '0;
        end else begin
            r_div <= sample_tick ? '0 : r_div + CW'(1);
            case (r_state)
                IDLE: begin
                    if (sample_tick) begin
                        r_x     <= sound_in;
                        r_k     <= w_k_sel;
                        r_state <= ST1;
                    end
                end
                ST1: begin
                    r_y1    <= w_y_next;
                    r_state <= ST2;
                end
                ST2: begin
                    r_y2    <= w_y_next;
                    r_state <= DONE;
                end
                default: begin
                    r_sound_out <= w_sat;
                    r_state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tp84_vol_lpf.sv
// Directed bench for tp84_vol_lpf: hand-computed vector table plus sequences
// for tick timing, coefficient switching, step response, attenuation and reset.
module tb_tp84_vol_lpf;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ST1  = 2'd1;
    localparam logic [1:0] S_ST2  = 2'd2;

    logic               clk_49m = 1'b0;
    logic               reset;
    logic signed [15:0] sound_in;
    logic        [1:0]  vol_sel;
    logic               sample_tick;
    logic signed [15:0] sound_out;
    logic               out_valid;
    logic        [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int    vol;
        int    sin;
        int    exp;
        string name;
    } vec_t;

    vec_t vecs[6];

    always #5 clk_49m = ~clk_49m;

    tp84_vol_lpf dut (
        .clk_49m     (clk_49m),
        .reset       (reset),
        .sound_in    (sound_in),
        .vol_sel     (vol_sel),
        .sample_tick (sample_tick),
        .sound_out   (sound_out),
        .out_valid   (out_valid),
        .o_dbg_state (o_dbg_state)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected=[%0d..%0d]", nm, act, lo, hi);
        end
    endtask

    // Reset is released on a falling edge, so the divider reads 0 on return.
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_49m);
        reset = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (!sample_tick && n < 2100) begin
            @(negedge clk_49m);
            n++;
        end
        if (!sample_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic wait_valid(output logic signed [15:0] v, output int lat);
        lat = 0;
        while (!out_valid && lat < 2100) begin
            @(negedge clk_49m);
            lat++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
        v = sound_out;
        @(negedge clk_49m);
    endtask

    task automatic run_sample(input int vol, input int sin, output logic signed [15:0] v);
        int lat;
        vol_sel  = 2'(vol);
        sound_in = 16'(sin);
        wait_valid(v, lat);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] v;
        int n, lat, prev, mn, mx, amp1, amp3, sat_hits;

        vecs[0] = '{vol: 0, sin: -1234,  exp: -1234, name: "byp_neg"};
        vecs[1] = '{vol: 0, sin: 32767,  exp: 32767, name: "byp_max"};
        vecs[2] = '{vol: 1, sin: -32768, exp: 8348,  name: "fullscale_swing"};
        vecs[3] = '{vol: 0, sin: 0,      exp: 0,     name: "byp_zero"};
        vecs[4] = '{vol: 1, sin: 16384,  exp: 6104,  name: "step_s1"};
        vecs[5] = '{vol: 1, sin: 16384,  exp: 10861, name: "step_s2"};

        reset    = 1'b1;
        sound_in = '0;
        vol_sel  = '0;
        do_reset();

        // Reset state and divider / latency timing
        chk("rst_sound_out", sound_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_tick", sample_tick, 0);
        chk("rst_state", o_dbg_state, S_IDLE);
        wait_tick(n);
        chk("first_tick", n, 1023);
        for (int i = 0; i < 2; i++) begin
            wait_valid(v, lat);
            chk("valid_latency", lat, 3);
            chk("idle_out", v, 0);
            wait_tick(n);
            chk("tick_period", n + 4, 1024);
        end
        wait_valid(v, lat);

        // Input is latched only on the tick
        vol_sel  = 2'd0;
        sound_in = 16'sd500;
        wait_tick(n);
        @(negedge clk_49m);
        sound_in = -16'sd7;
        wait_valid(v, lat);
        chk("latch_on_tick", v, 500);
        repeat (100) @(negedge clk_49m);
        chk("out_held", sound_out, 500);

        for (int i = 0; i < 6; i++) begin
            run_sample(vecs[i].vol, vecs[i].sin, v);
            chk(vecs[i].name, v, vecs[i].exp);
        end

        // Step response keeps rising and never overshoots
        prev = 10861;
        for (int i = 0; i < 12; i++) begin
            run_sample(1, 16384, v);
            chk_range("step_mono", v, prev, 16386);
            prev = v;
        end
        chk_range("step_final", v, 16382, 16386);

        // Coefficient change inside ST1 applies from the next tick only
        run_sample(0, 0, v);
        chk("coef_clear", v, 0);
        vol_sel  = 2'd1;
        sound_in = 16'sd16384;
        wait_tick(n);
        @(negedge clk_49m);
        chk("coef_in_st1", o_dbg_state, S_ST1);
        vol_sel = 2'd3;
        wait_valid(v, lat);
        chk("coef_old_used", v, 6104);
        wait_valid(v, lat);
        chk("coef_new_used", v, 8043);

        // 24 kHz alternation: heavier roll-off at vol_sel=3
        do_reset();
        mn = 32767; mx = -32768; sat_hits = 0;
        for (int i = 0; i < 10; i++) begin
            run_sample(1, (i % 2 == 0) ? 32767 : -32767, v);
            if (v >= 32767 || v <= -32767) sat_hits++;
            if (i >= 6) begin
                if (v < mn) mn = v;
                if (v > mx) mx = v;
            end
        end
        amp1 = (mx - mn) / 2;
        chk_range("alt_amp_vol1", amp1, 6000, 6700);
        chk("alt_nosat_vol1", sat_hits, 0);
        do_reset();
        mn = 32767; mx = -32768; sat_hits = 0;
        for (int i = 0; i < 24; i++) begin
            run_sample(3, (i % 2 == 0) ? 32767 : -32767, v);
            if (v >= 32767 || v <= -32767) sat_hits++;
            if (i >= 20) begin
                if (v < mn) mn = v;
                if (v > mx) mx = v;
            end
        end
        amp3 = (mx - mn) / 2;
        chk_range("alt_amp_vol3_ratio", amp3 * 5, 0, amp1 - 1);
        chk("alt_nosat_vol3", sat_hits, 0);

        // Reset during ST2
        do_reset();
        run_sample(1, 16384, v);
        chk("pre_reset_sample", v, 6104);
        wait_tick(n);
        @(negedge clk_49m);
        @(negedge clk_49m);
        chk("in_st2", o_dbg_state, S_ST2);
        reset = 1'b1;
        @(negedge clk_49m);
        chk("st2_rst_state", o_dbg_state, S_IDLE);
        chk("st2_rst_sound_out", sound_out, 0);
        chk("st2_rst_out_valid", out_valid, 0);
        reset = 1'b0;
        wait_tick(n);
        chk("st2_rst_div_restart", n, 1023);
        chk("st2_rst_out_unchanged", sound_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
